mem_access_stage: RTL
=====================

Name:
mem_access_stage

Overview:
MEM stage, fed by the EX/MEM register. Drives a req/ack data-memory bus for loads and stores and stalls upstream (drives its stop) while an access is pending. Performs byte/half lane steering, load extension and misalignment and timeout detection, and registers results for WB.

Parameters:
TIMEOUT, 255, max BUSY cycles waiting for dmem_ack before abort; 0 = never time out

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
nop  in  1  bubble marker from EX/MEM
pc  in  32  instruction PC
res  in  32  ALU result; address for memory ops, writeback value otherwise
reg1  in  32  store data
rd  in  5  destination register
reg_write  in  1  writes rd
mem_write  in  1  store
mem_to_reg  in  1  load
load_unsigned  in  1  zero-extend load
ls_byte  in  1  byte access
half  in  1  halfword access (ls_byte has priority)
ebreak  in  1  ebreak marker
stall_req  out  1  combinational freeze request to upstream registers
dmem_req  out  1  bus request, high exactly while state==BUSY
dmem_we  out  1  write enable, valid with dmem_req
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  access complete; dmem_rdata valid same cycle
dmem_rdata  in  32  read word
nop_out  out  1  bubble to WB
pc_out  out  32  registered pc
wb_data_out  out  32  load result or res
rd_out  out  5  registered rd
reg_write_out  out  1  registered write enable, forced 0 on exception
ebreak_out  out  1  registered ebreak
exc_out  out  2  01 misaligned, 10 bus timeout, 00 none

Behaviour:
- Reset (rst at posedge): state IDLE, wait counter 0. nop_out=1. All other registered outputs 0. dmem_req=0.
- mem_op = !nop & (mem_write|mem_to_reg).
- Misaligned: half & addr[0], or word & addr[1:0]!=0. Byte accesses are never misaligned.
- IDLE, non-memory op or nop: next edge registers inputs to outputs with wb_data_out=res and exc_out=00. 1-cycle latency. stall_req=0.
- IDLE, misaligned mem_op: no bus access. Next edge gives nop_out=0, exc_out=01, reg_write_out=0. stall_req=0.
- IDLE, aligned mem_op: stall_req=1. Latch address, size, we, sign and control fields. Go to BUSY. Next edge nop_out=1.
- BUSY: dmem_req=1 and all bus fields held stable from the latched copy. Live inputs are ignored.
- BUSY, no ack: stall_req=1, counter increments, nop_out=1.
- BUSY, ack: stall_req=0, so upstream advances on the same edge. Outputs are registered from the latched copy and the state returns to IDLE. Load-to-WB latency is ≥2 cycles.
- BUSY, TIMEOUT!=0 and counter==TIMEOUT-1 without ack: abort. stall_req=0, exc_out=10, reg_write_out=0, nop_out=0, back to IDLE. A late ack is ignored while IDLE.
- Store lanes by addr[1:0]:
  - byte: be=1<<addr[1:0], wdata={4{reg1[7:0]}}
  - half: be=addr[1]?1100:0011, wdata={2{reg1[15:0]}}
  - word: be=1111, wdata=reg1
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8]
  - half = rdata[16*addr[1]+:16]
  - sign-extended unless load_unsigned.
- Stores force reg_write_out=0. ebreak passes with its instruction.
- rst while BUSY: next cycle IDLE, dmem_req=0, stall_req=0, and the pending access is dropped.

Test Plan:
- ALU op res=0x1234, rd=5, reg_write=1 -> next cycle wb_data_out=0x1234, rd_out=5, stall_req never high.
- lb addr 0x103, rdata 0x80FFFFFF, ack 2 cycles after req -> stall_req high 3 cycles, then wb_data_out=0xFFFFFF80; with load_unsigned it is 0x00000080.
- sh reg1=0xABCD1234 addr 0x202 -> dmem_addr=0x200, be=1100, wdata=0x12341234, we=1, reg_write_out=0.
- lw addr 0x101 -> no dmem_req, exc_out=01, reg_write_out=0, 1-cycle latency.
- TIMEOUT=4, never ack -> dmem_req for 4 cycles, then exc_out=10 and stall_req drops; rst asserted mid-BUSY -> dmem_req=0 next cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with req/ack data bus, lane steering, load extension and timeout abort
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_nop,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_res,
  input  logic [31:0] i_reg1,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_write,
  input  logic        i_mem_write,
  input  logic        i_mem_to_reg,
  input  logic        i_load_unsigned,
  input  logic        i_ls_byte,
  input  logic        i_half,
  input  logic        i_ebreak,
  output logic        o_stall_req,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_nop_out,
  output logic [31:0] o_pc_out,
  output logic [31:0] o_wb_data_out,
  output logic [4:0]  o_rd_out,
  output logic        o_reg_write_out,
  output logic        o_ebreak_out,
  output logic [1:0]  o_exc_out
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [31:0] r_cnt, r_pc, r_addr, r_data;
  logic [4:0]  r_rd;
  logic        r_rw, r_we, r_ld, r_uns, r_byte, r_half, r_eb;
  logic        w_busy, w_mem_op, w_mis, w_start, w_to;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_load;
  always_comb begin
    w_busy = r_state == BUSY;
    w_mem_op = ~i_nop & (i_mem_write | i_mem_to_reg);
    w_mis = (~i_ls_byte & i_half & i_res[0]) | (~i_ls_byte & ~i_half & |i_res[1:0]);
    w_start = ~w_busy & w_mem_op & ~w_mis;
    w_to = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));
    w_next = w_busy ? ((i_dmem_ack | w_to) ? IDLE : BUSY) : (w_start ? BUSY : IDLE);
    o_stall_req = w_start | (w_busy & ~i_dmem_ack & ~w_to);
    o_dmem_req = w_busy;
    o_dmem_we = w_busy & r_we;
    o_dmem_addr = {r_addr[31:2], 2'b00};
    o_dmem_be = r_byte ? 4'b0001 << r_addr[1:0] : r_half ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_dmem_wdata = r_byte ? {4{r_data[7:0]}} : r_half ? {2{r_data[15:0]}} : r_data;
    w_b = i_dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_h = i_dmem_rdata[{r_addr[1], 4'b0000} +: 16];
    w_load = r_byte ? {{24{~r_uns & w_b[7]}}, w_b} : r_half ? {{16{~r_uns & w_h[15]}}, w_h} : i_dmem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_busy & ~i_dmem_ack) ? r_cnt + 32'd1 : '0;
    end
  end
  // bus fields are frozen here so the live EX/MEM inputs can be ignored while BUSY
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_pc <= i_pc;
      r_addr <= i_res;
      r_data <= i_reg1;
      r_rd <= i_rd;
      r_rw <= i_reg_write;
      r_we <= i_mem_write;
      r_ld <= i_mem_to_reg;
      r_uns <= i_load_unsigned;
      r_byte <= i_ls_byte;
      r_half <= ~i_ls_byte & i_half;
      r_eb <= i_ebreak;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_nop_out <= 1'b1;
      o_pc_out <= '0;
      o_wb_data_out <= '0;
      o_rd_out <= '0;
      o_reg_write_out <= 1'b0;
      o_ebreak_out <= 1'b0;
      o_exc_out <= 2'b00;
    end else if (w_busy & (i_dmem_ack | w_to)) begin
      o_nop_out <= 1'b0;
      o_pc_out <= r_pc;
      o_wb_data_out <= (i_dmem_ack & r_ld) ? w_load : r_addr;
      o_rd_out <= r_rd;
      o_reg_write_out <= i_dmem_ack & r_rw & ~r_we;
      o_ebreak_out <= r_eb;
      o_exc_out <= i_dmem_ack ? 2'b00 : 2'b10;
    end else if (w_busy | w_start) begin
      o_nop_out <= 1'b1;
      o_reg_write_out <= 1'b0;
      o_ebreak_out <= 1'b0;
      o_exc_out <= 2'b00;
    end else begin
      o_nop_out <= i_nop & ~w_mem_op;
      o_pc_out <= i_pc;
      o_wb_data_out <= i_res;
      o_rd_out <= i_rd;
      o_reg_write_out <= i_reg_write & ~i_mem_write & ~w_mem_op;
      o_ebreak_out <= i_ebreak;
      o_exc_out <= w_mem_op ? 2'b01 : 2'b00;
    end
  end
endmodule
